// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, branch flush and forwarding-select control for an in-order pipeline.
// Optional performance counters are enabled by defining PIPE_HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  localparam int FWD_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wr_en,
  input  logic                  id_is_load,
  input  logic                  br_taken,
  input  logic                  ext_stall,
  output logic                  stall,
  output logic                  bubble_ex,
  output logic                  flush_if_id,
  output logic [FWD_W-1:0]      fwd_a,
  output logic [FWD_W-1:0]      fwd_b
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  // Entry k describes the instruction currently in stage EXE+k.
  logic [DEPTH-1:0]      entValid;
  logic [DEPTH-1:0]      entIsLoad;
  logic [REG_ADDR_W-1:0] entRd [DEPTH];

  logic rs1Live;
  logic rs2Live;
  logic idWriter;
  logic loadUse;

  assign rs1Live  = id_rs1_used & (id_rs1 != '0);
  assign rs2Live  = id_rs2_used & (id_rs2 != '0);
  assign idWriter = id_valid & id_wr_en & (id_rd != '0);

  assign loadUse = id_valid & entValid[0] & entIsLoad[0] &
                   ((rs1Live & (id_rs1 == entRd[0])) |
                    (rs2Live & (id_rs2 == entRd[0])));

  // A freeze masks everything; a taken branch already squashes the dependent instruction.
  assign stall       = ext_stall | (loadUse & ~br_taken);
  assign bubble_ex   = ~ext_stall & (br_taken | loadUse);
  assign flush_if_id = ~ext_stall & br_taken;

  // Scan oldest to youngest so the youngest matching producer overrides.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rs1Live && entValid[k] && (entRd[k] == id_rs1)) begin
        fwd_a = FWD_W'(k + 1);
      end
      if (rs2Live && entValid[k] && (entRd[k] == id_rs2)) begin
        fwd_b = FWD_W'(k + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entValid  <= '0;
      entIsLoad <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        entRd[k] <= '0;
      end
    end else if (!ext_stall) begin
      for (int k = 1; k < DEPTH; k++) begin
        entValid[k]  <= entValid[k-1];
        entIsLoad[k] <= entIsLoad[k-1];
        entRd[k]     <= entRd[k-1];
      end
      entValid[0]  <= idWriter & ~bubble_ex;
      entIsLoad[0] <= id_is_load;
      entRd[0]     <= id_rd;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic stallEvent;

  assign stallEvent = loadUse & ~br_taken & ~ext_stall;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stallEvent && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (flush_if_id && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter REG_ADDR_W, default 5, register-address width.
REQ-002 Parameter DEPTH, default 3, number of tracked in-flight writer stages (EXE, MEM, WB); legal range 1..7.
REQ-003 Derived width FWD_W = clog2(DEPTH+1), which is 2 at the defaults.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  the single clock.
- rst  in  1  reset; asynchronous, active-low.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs1, id_rs2  in  REG_ADDR_W  source register addresses.
- id_rs1_used, id_rs2_used  in  1  the source is read.
- id_rd  in  REG_ADDR_W  destination register address.
- id_wr_en  in  1  the instruction writes a register.
- id_is_load  in  1  the instruction is a load.
- br_taken  in  1  taken branch or jump resolved in EXE.
- ext_stall  in  1  whole-pipeline freeze, e.g. a memory wait.
- stall  out  1  hold the PC and the IF/ID register.
- bubble_ex  out  1  load a NOP into the ID/EXE register.
- flush_if_id  out  1  clear the IF/ID register.
- fwd_a, fwd_b  out  FWD_W  forwarding select: 0 = register file; k = stage EXE+k-1.

Function
REQ-005 The block SHALL keep a scoreboard of DEPTH entries {valid, rd, is_load}; entry k describes the instruction currently in stage EXE+k.
REQ-006 An ID instruction SHALL be writer-eligible only when id_valid=1, id_wr_en=1 and id_rd is not 0.
REQ-007 Load-use hazard lu SHALL be true when all of the following hold:
- id_valid=1 and entry0.valid=1 and entry0.is_load=1;
- (id_rs1_used=1 and id_rs1 = entry0.rd and id_rs1 is not 0) or the same condition on rs2.
REQ-008 Output equations (combinational):
- stall = ext_stall | (lu & ~br_taken)
- bubble_ex = ~ext_stall & (br_taken | lu)
- flush_if_id = ~ext_stall & br_taken
REQ-009 Priority SHALL be ext_stall first, then br_taken, then lu. A branch that arrives together with ext_stall is acted on in the first cycle after the freeze releases.
REQ-010 When ext_stall=1, every scoreboard entry SHALL hold its value.
REQ-011 Otherwise, on each rising clock edge:
- entry[k+1] SHALL take entry[k], for k from 0 to DEPTH-2;
- the oldest entry SHALL be discarded;
- entry0 SHALL load the ID instruction if bubble_ex=0 and it is writer-eligible, and SHALL be invalid otherwise.
REQ-012 fwd_a SHALL equal k+1 for the smallest k whose entry is valid with rd = id_rs1, provided id_rs1_used=1 and id_rs1 is not 0; otherwise fwd_a SHALL be 0. fwd_b SHALL follow the same rule using rs2.
REQ-013 If several entries match, the youngest (lowest k) SHALL win. When fwd is nonzero, a register-file write to the same register in the same cycle SHALL be ignored.
REQ-014 The fwd outputs SHALL be valid in every cycle, including stall cycles. Register address 0 SHALL never stall and never forward.
REQ-015 A hazard cleared by a bubble SHALL cost exactly 1 stall cycle per load-use pair. Forwarding SHALL add 0 cycles of latency.

Reset
REQ-016 While rst=0, all scoreboard entries SHALL be invalid, whatever the other inputs are.
REQ-017 Consequently, during reset stall=ext_stall, and fwd_a=fwd_b=0.
REQ-018 A reset that arrives mid-stall SHALL drop all pending hazards. After the first edge following release, the block SHALL behave as though the pipeline is empty.

Configuration
REQ-019 With macro PIPE_HAZARD_PERF_EN defined, the block SHALL add the following outputs:
- perf_stall_cnt (32 bits), incremented on each clock edge where lu & ~br_taken & ~ext_stall is true;
- perf_flush_cnt (32 bits), incremented on each edge where flush_if_id=1.
REQ-020 Both counters SHALL saturate at 0xFFFFFFFF and SHALL reset to 0.
REQ-021 Without PIPE_HAZARD_PERF_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-022 Load-use: a load with rd=5 is followed immediately by an instruction with rs1=5 -> stall=1 and bubble_ex=1 for exactly 1 cycle, then fwd_a=2.
REQ-023 ALU chain: an ALU op with rd=3, then rs2=3 next cycle -> fwd_b=1 with no stall; two cycles later, a reader of x3 gets fwd=2.
REQ-024 Youngest wins: writes to x7 in consecutive cycles, then a reader of x7 -> fwd_a=1, not 2; rd=0 writers never produce a match.
REQ-025 Priority: br_taken=1 together with lu=1 -> stall=0, flush_if_id=1, bubble_ex=1; then ext_stall=1 for 3 cycles -> scoreboard unchanged, bubble_ex=0.
REQ-026 Reset: rst=0 asserted while entries are valid -> fwd_a=fwd_b=0 and stall=0 immediately (with ext_stall=0).
REQ-027 With PIPE_HAZARD_PERF_EN defined: 4 load-use stalls and 2 branches -> perf_stall_cnt=4 and perf_flush_cnt=2. A counter preloaded to 0xFFFFFFFF by force SHALL stay at 0xFFFFFFFF.
